// File: rtl/tableau_stream_ctrl.sv
// Tableau store, gate queue and row streamer feeding the CBA stage.
// One gate at a time: stream every row out, collect every result row,
// write the results back, then take the next gate from the queue.
module tableau_stream_ctrl #(
  parameter int num_qubit       = 4,
  parameter int gate_fifo_depth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_valid,
  input  logic [2*num_qubit-1:0] init_literal,
  input  logic                   init_phase,
  input  logic                   gate_valid,
  output logic                   gate_ready,
  input  logic [2:0]             gate_type_in,
  input  logic [31:0]            qubit_pos_in,
  input  logic [31:0]            qubit_pos2_in,
  output logic                   row_valid_out,
  output logic [2*num_qubit-1:0] literal_out,
  output logic                   phase_out,
  output logic [2:0]             gate_type,
  output logic [31:0]            qubit_pos,
  output logic [31:0]            qubit_pos2,
  input  logic                   row_valid_in,
  input  logic [2*num_qubit-1:0] literal_in,
  input  logic                   phase_in,
  input  logic                   dump_req,
  output logic                   dump_valid,
  output logic                   busy,
  output logic [31:0]            gates_done,
  output logic                   err_illegal,
  output logic                   err_unexpected
);

  localparam int LW = 2 * num_qubit;
  localparam int IW = (num_qubit > 1) ? $clog2(num_qubit) : 1;
  localparam int PW = (gate_fifo_depth > 1) ? $clog2(gate_fifo_depth) : 1;
  localparam logic [IW-1:0] LAST   = IW'(num_qubit - 1);
  localparam logic [PW:0]   FULL_C = (PW+1)'(gate_fifo_depth);

  typedef enum logic [2:0] {S_IDLE, S_READY, S_SEND, S_WAIT, S_DUMP} state_t;

  typedef struct packed {
    logic [2:0]  gtype;
    logic [31:0] pos;
    logic [31:0] pos2;
  } gate_t;

  state_t state, state_d;
  logic [IW-1:0] idx, idx_d, emit_idx;

  logic [num_qubit-1:0][LW-1:0] tab_lit;
  logic [num_qubit-1:0]         tab_ph;

  gate_t         fifo_mem [gate_fifo_depth];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_cnt, cnt_d;
  gate_t         head;
  logic          push, pop, legal;

  logic init_wr, res_wr, issue, emit_row, emit_dump, gate_done;

  assign head = fifo_mem[rd_ptr];
  assign push = gate_valid && gate_ready;

  // Legality of the gate at the queue head, checked as it is popped
  always_comb begin
    legal = 1'b1;
    if (head.gtype > 3'd2) legal = 1'b0;
    if (head.pos >= 32'(num_qubit)) legal = 1'b0;
    if (head.gtype == 3'd2 && (head.pos2 >= 32'(num_qubit) || head.pos == head.pos2))
      legal = 1'b0;
  end

  // Queue occupancy after this cycle's push/pop
  always_comb begin
    cnt_d = fifo_cnt;
    if (push && !pop)      cnt_d = fifo_cnt + (PW+1)'(1);
    else if (!push && pop) cnt_d = fifo_cnt - (PW+1)'(1);
  end

  // Gate queue storage and pointers; gate_ready is the registered not-full flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      gate_ready <= 1'b1;
      for (int i = 0; i < gate_fifo_depth; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {gate_type_in, qubit_pos_in, qubit_pos2_in};
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt   <= cnt_d;
      gate_ready <= (cnt_d != FULL_C);
    end
  end

  // State and row index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  // Next state, row index and per-cycle datapath controls
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    emit_idx  = idx;
    init_wr   = 1'b0;
    res_wr    = 1'b0;
    pop       = 1'b0;
    issue     = 1'b0;
    emit_row  = 1'b0;
    emit_dump = 1'b0;
    gate_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (init_valid) begin
          init_wr = 1'b1;
          if (idx == LAST) begin
            state_d = S_READY;
            idx_d   = '0;
          end else begin
            idx_d = idx + IW'(1);
          end
        end
      end
      S_READY: begin
        emit_idx = '0;
        if (dump_req) begin
          // Row 0 goes out on this edge; DUMP covers the remaining rows
          emit_dump = 1'b1;
          state_d   = (num_qubit == 1) ? S_READY : S_DUMP;
          idx_d     = (num_qubit == 1) ? '0 : IW'(1);
        end else if (fifo_cnt != '0) begin
          pop = 1'b1;
          if (legal) begin
            issue    = 1'b1;
            emit_row = 1'b1;
            state_d  = (num_qubit == 1) ? S_WAIT : S_SEND;
            idx_d    = (num_qubit == 1) ? '0 : IW'(1);
          end
        end
      end
      S_SEND: begin
        emit_row = 1'b1;
        if (idx == LAST) begin
          state_d = S_WAIT;
          idx_d   = '0;
        end else begin
          idx_d = idx + IW'(1);
        end
      end
      S_WAIT: begin
        if (row_valid_in) begin
          res_wr = 1'b1;
          if (idx == LAST) begin
            gate_done = 1'b1;
            state_d   = S_READY;
            idx_d     = '0;
          end else begin
            idx_d = idx + IW'(1);
          end
        end
      end
      S_DUMP: begin
        emit_dump = 1'b1;
        if (idx == LAST) begin
          state_d = S_READY;
          idx_d   = '0;
        end else begin
          idx_d = idx + IW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Tableau writes: initial load in IDLE, CBA results in WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tab_lit <= '0;
      tab_ph  <= '0;
    end else if (init_wr) begin
      tab_lit[idx] <= init_literal;
      tab_ph[idx]  <= init_phase;
    end else if (res_wr) begin
      tab_lit[idx] <= literal_in;
      tab_ph[idx]  <= phase_in;
    end
  end

  // Registered outputs: row stream, current gate, counters and error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_valid_out  <= 1'b0;
      dump_valid     <= 1'b0;
      literal_out    <= '0;
      phase_out      <= 1'b0;
      gate_type      <= '0;
      qubit_pos      <= '0;
      qubit_pos2     <= '0;
      gates_done     <= '0;
      err_illegal    <= 1'b0;
      err_unexpected <= 1'b0;
      busy           <= 1'b0;
    end else begin
      row_valid_out <= emit_row;
      dump_valid    <= emit_dump;
      if (emit_row || emit_dump) begin
        literal_out <= tab_lit[emit_idx];
        phase_out   <= tab_ph[emit_idx];
      end else begin
        literal_out <= '0;
        phase_out   <= 1'b0;
      end
      // Gate fields stay put for the whole SEND/WAIT window
      if (issue) begin
        gate_type  <= head.gtype;
        qubit_pos  <= head.pos;
        qubit_pos2 <= head.pos2;
      end else if (gate_done) begin
        gate_type  <= '0;
        qubit_pos  <= '0;
        qubit_pos2 <= '0;
      end
      if (gate_done) gates_done <= gates_done + 32'd1;
      err_illegal    <= pop && !legal;
      err_unexpected <= row_valid_in && (state != S_WAIT);
      busy           <= (state_d != S_IDLE) && (state_d != S_READY);
    end
  end

endmodule

// File: tb/tb_tableau_stream_ctrl.sv
// Directed bench for tableau_stream_ctrl with an XOR-mask CBA stub.
module tb_tableau_stream_ctrl;
  localparam int NQ = 4;
  localparam int LW = 2 * NQ;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_valid, init_phase, gate_valid, gate_ready;
  logic [LW-1:0] init_literal, literal_out, literal_in;
  logic [2:0]    gate_type_in, gate_type;
  logic [31:0]   qubit_pos_in, qubit_pos2_in, qubit_pos, qubit_pos2, gates_done;
  logic          row_valid_out, phase_out, row_valid_in, phase_in;
  logic          dump_req, dump_valid, busy, err_illegal, err_unexpected;

  always #5 clk = ~clk;

  tableau_stream_ctrl #(.num_qubit(NQ), .gate_fifo_depth(8)) dut (
    .clk(clk), .rst(rst),
    .init_valid(init_valid), .init_literal(init_literal), .init_phase(init_phase),
    .gate_valid(gate_valid), .gate_ready(gate_ready),
    .gate_type_in(gate_type_in), .qubit_pos_in(qubit_pos_in), .qubit_pos2_in(qubit_pos2_in),
    .row_valid_out(row_valid_out), .literal_out(literal_out), .phase_out(phase_out),
    .gate_type(gate_type), .qubit_pos(qubit_pos), .qubit_pos2(qubit_pos2),
    .row_valid_in(row_valid_in), .literal_in(literal_in), .phase_in(phase_in),
    .dump_req(dump_req), .dump_valid(dump_valid), .busy(busy),
    .gates_done(gates_done), .err_illegal(err_illegal), .err_unexpected(err_unexpected)
  );

  typedef struct {
    logic [2:0]  t;
    logic [31:0] p;
    logic [31:0] p2;
  } gate_t;

  int n_pass = 0, n_chk = 0;

  // scoreboards
  gate_t         exp_gates[$];
  logic [LW-1:0] exp_dump_lit[$];
  logic          exp_dump_ph[$];
  logic [LW-1:0] model_lit [NQ];
  logic          model_ph  [NQ];

  // CBA stub state and knobs
  int            cyc = 0, snd_i = 0, dmp_i = 0, ret_i = 0, ret_next = 0;
  int            ret_delay = 5, gap = 0, ret_limit = NQ, exp_done = 0;
  int            n_illegal = 0, n_unexp = 0;
  bit            in_gate = 0, captured = 0, stall = 0, inject = 0;
  gate_t         cur;
  logic [LW-1:0] cap_lit [NQ];
  logic          cap_ph  [NQ];
  logic [LW-1:0] mask = '0;
  logic          pmask = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Monitors outputs and plays the CBA: returns captured rows XOR mask
  task cba_stub();
    forever begin
      @(negedge clk);
      cyc++;
      row_valid_in = 1'b0;
      literal_in   = '0;
      phase_in     = 1'b0;
      if (err_illegal)    n_illegal++;
      if (err_unexpected) n_unexp++;
      if (dump_valid) begin
        chk("dump_row_valid_low", {63'd0, row_valid_out}, 64'd0);
        if (exp_dump_lit.size() == 0) chk("dump_expected", 64'(exp_dump_lit.size()), 64'd1);
        else begin
          chk("dump_lit", {56'd0, literal_out}, {56'd0, exp_dump_lit.pop_front()});
          chk("dump_ph", {63'd0, phase_out}, {63'd0, exp_dump_ph.pop_front()});
        end
        dmp_i = (dmp_i + 1) % NQ;
      end else if (dmp_i != 0) begin
        chk("dump_consecutive", {63'd0, dump_valid}, 64'd1);
        dmp_i = 0;
      end
      if (row_valid_out) begin
        if (snd_i == 0) begin
          if (exp_gates.size() == 0) chk("gate_expected", 64'(exp_gates.size()), 64'd1);
          else begin
            cur     = exp_gates.pop_front();
            in_gate = 1;
          end
        end
        chk("send_lit", {56'd0, literal_out}, {56'd0, model_lit[snd_i]});
        chk("send_ph", {63'd0, phase_out}, {63'd0, model_ph[snd_i]});
        cap_lit[snd_i] = literal_out;
        cap_ph[snd_i]  = phase_out;
        if (snd_i == NQ - 1) begin
          captured = 1;
          ret_i    = 0;
          ret_next = cyc + ret_delay;
        end
        snd_i = (snd_i + 1) % NQ;
      end else if (snd_i != 0) begin
        chk("send_consecutive", {63'd0, row_valid_out}, 64'd1);
        snd_i = 0;
      end
      if (in_gate) begin
        chk("busy_in_gate", {63'd0, busy}, 64'd1);
        chk("gate_type_hold", {61'd0, gate_type}, {61'd0, cur.t});
        chk("qubit_pos_hold", {32'd0, qubit_pos}, {32'd0, cur.p});
        chk("qubit_pos2_hold", {32'd0, qubit_pos2}, {32'd0, cur.p2});
      end else if (!busy) begin
        chk("gate_zero_idle", {61'd0, gate_type} | {32'd0, qubit_pos} | {32'd0, qubit_pos2}, 64'd0);
      end
      chk("gates_done", {32'd0, gates_done}, 64'(exp_done));
      if (captured && !stall && ret_i < ret_limit && cyc >= ret_next) begin
        row_valid_in = 1'b1;
        literal_in   = cap_lit[ret_i] ^ mask;
        phase_in     = cap_ph[ret_i] ^ pmask;
        ret_i++;
        ret_next = cyc + 1 + gap;
        if (ret_i == NQ) begin
          for (int r = 0; r < NQ; r++) begin
            model_lit[r] = model_lit[r] ^ mask;
            model_ph[r]  = model_ph[r] ^ pmask;
          end
          in_gate  = 0;
          captured = 0;
          ret_i    = 0;
          exp_done++;
        end
      end else if (inject) begin
        row_valid_in = 1'b1;
        literal_in   = '1;
        phase_in     = 1'b1;
        inject       = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rvo"}, {63'd0, row_valid_out}, 64'd0);
    chk({tag, "_lit"}, {56'd0, literal_out}, 64'd0);
    chk({tag, "_ph"}, {63'd0, phase_out}, 64'd0);
    chk({tag, "_gate"}, {61'd0, gate_type} | {32'd0, qubit_pos} | {32'd0, qubit_pos2}, 64'd0);
    chk({tag, "_dump"}, {63'd0, dump_valid}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {32'd0, gates_done}, 64'd0);
    chk({tag, "_errs"}, {62'd0, err_illegal, err_unexpected}, 64'd0);
    chk({tag, "_ready"}, {63'd0, gate_ready}, 64'd1);
  endtask

  task automatic init_identity();
    for (int r = 0; r < NQ; r++) begin
      init_valid   = 1'b1;
      init_literal = LW'(2) << (2 * r);
      init_phase   = 1'b0;
      model_lit[r] = LW'(2) << (2 * r);
      model_ph[r]  = 1'b0;
      tick();
    end
    init_valid   = 1'b0;
    init_literal = '0;
  endtask

  task automatic dump_check(input string tag);
    for (int r = 0; r < NQ; r++) begin
      exp_dump_lit.push_back(model_lit[r]);
      exp_dump_ph.push_back(model_ph[r]);
    end
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int k = 0; k < 20 && exp_dump_lit.size() != 0; k++) tick();
    repeat (2) tick();
    chk({tag, "_dump_drained"}, 64'(exp_dump_lit.size()), 64'd0);
  endtask

  task automatic push(input logic [2:0] t, input logic [31:0] p, input logic [31:0] p2,
                      input bit legal, input int budget, output bit acc);
    logic r;
    gate_t g;
    gate_valid    = 1'b1;
    gate_type_in  = t;
    qubit_pos_in  = p;
    qubit_pos2_in = p2;
    acc = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      r = gate_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc = 1;
        break;
      end
    end
    gate_valid = 1'b0;
    if (acc && legal) begin
      g.t = t; g.p = p; g.p2 = p2;
      exp_gates.push_back(g);
    end
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    for (int k = 0; k < budget && !(exp_done == target && !busy); k++) tick();
    chk({tag, "_done_count"}, 64'(exp_done), 64'(target));
    chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    bit acc;
    rst = 1'b1;
    init_valid = 1'b0; init_literal = '0; init_phase = 1'b0;
    gate_valid = 1'b0; gate_type_in = '0; qubit_pos_in = '0; qubit_pos2_in = '0;
    dump_req = 1'b0; row_valid_in = 1'b0; literal_in = '0; phase_in = 1'b0;
    for (int r = 0; r < NQ; r++) begin model_lit[r] = '0; model_ph[r] = 1'b0; end
    fork cba_stub(); join_none
    repeat (2) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // identity load and readout
    init_identity();
    tick();
    dump_check("ident");

    // H on qubit 0, stub flips bits 0/1 of every row
    mask = 8'h03; pmask = 1'b0;
    push(3'd0, 32'd0, 32'd0, 1, 5, acc);
    chk("h_accept", {63'd0, acc}, 64'd1);
    wait_done("h", 1, 100);
    dump_check("h");

    // illegal gates dropped, P(3) still issued
    mask = 8'h5A; pmask = 1'b1;
    push(3'd2, 32'd1, 32'd1, 0, 5, acc);
    push(3'd3, 32'd0, 32'd0, 0, 5, acc);
    push(3'd0, 32'd4, 32'd0, 0, 5, acc);
    push(3'd2, 32'd0, 32'd7, 0, 5, acc);
    push(3'd1, 32'd3, 32'd0, 1, 5, acc);
    wait_done("illegal", 2, 100);
    chk("illegal_pulses", 64'(n_illegal), 64'd4);

    // result rows with 2-cycle gaps
    mask = 8'hC3; pmask = 1'b0; gap = 2;
    push(3'd2, 32'd0, 32'd2, 1, 5, acc);
    wait_done("gaps", 3, 100);
    dump_check("gaps");

    // fill the queue behind a stalled gate
    gap = 0; stall = 1; mask = 8'h21; pmask = 1'b1;
    push(3'd1, 32'd1, 32'd0, 1, 5, acc);
    repeat (12) tick();
    for (int i = 0; i < 8; i++) begin
      push(3'(i % 3), 32'(i % NQ), 32'((i + 1) % NQ), 1, 1, acc);
      chk("fill_accept", {63'd0, acc}, 64'd1);
    end
    chk("ready_full", {63'd0, gate_ready}, 64'd0);
    push(3'd0, 32'd2, 32'd0, 1, 4, acc);
    chk("ninth_held", {63'd0, acc}, 64'd0);
    stall = 0;
    push(3'd0, 32'd2, 32'd0, 1, 60, acc);
    chk("ninth_accept", {63'd0, acc}, 64'd1);
    wait_done("fill", 13, 1000);
    chk("fill_queue_empty", 64'(exp_gates.size()), 64'd0);
    dump_check("fill");
    chk("no_unexpected", 64'(n_unexp), 64'd0);

    // reset in WAIT after two returned rows
    ret_limit = 2;
    push(3'd0, 32'd2, 32'd0, 1, 5, acc);
    for (int k = 0; k < 60 && ret_i < 2; k++) tick();
    chk("two_rows_returned", 64'(ret_i), 64'd2);
    tick();
    rst = 1'b1;
    in_gate = 0; captured = 0; ret_i = 0; snd_i = 0; dmp_i = 0; exp_done = 0;
    exp_gates.delete();
    for (int r = 0; r < NQ; r++) begin model_lit[r] = '0; model_ph[r] = 1'b0; end
    #1;
    chk_reset_outputs("midreset");
    tick();
    rst = 1'b0;
    ret_limit = NQ;
    tick();
    inject = 1;
    repeat (3) tick();
    chk("unexpected_pulse", 64'(n_unexp), 64'd1);
    chk("inject_busy", {63'd0, busy}, 64'd0);
    chk("inject_done", {32'd0, gates_done}, 64'd0);
    init_identity();
    tick();
    dump_check("reinit");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
